// File: rtl/greater_stream.sv
// -----------------------------------------------------------------------------
// greater_stream
//
// Handshaked WIDTH-bit magnitude comparator with a frame peak tracker.
// Each accepted beat (in_valid && in_ready) compares operands a and b. The
// greater/equal/less flags and a mode-selected relation appear one cycle
// later behind a single-entry valid/ready output register. In parallel, the
// block tracks the maximum of a across a frame delimited by in_last. At frame
// end it publishes that maximum, the index of its first occurrence, the
// saturating beat count and an overflow flag.
//
// Parameters:
//   WIDTH  - operand width in bits (>= 2)
//   SIGNED - 0: unsigned compare, 1: two's-complement compare (relations and
//            frame max)
//   CNT_W  - width of the frame index / count fields
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid / in_ready   - input handshake (in_ready = !out_valid || out_ready)
//   a, b                  - operands
//   mode                  - relation select: 00 a>b, 01 a>=b, 10 a<b, 11 a==b
//   in_last               - beat closes the current frame
//   out_valid / out_ready - result handshake
//   greater/equal/less    - one-hot relation flags of the beat
//   result                - relation selected by that beat's mode
//   frame_valid           - one-cycle pulse, frame summary updated
//   frame_max             - maximum a seen in the frame
//   frame_max_idx         - 0-based index of the first occurrence of frame_max
//   frame_count           - beats in the frame, saturating at 2^CNT_W-1
//   frame_ovf             - the frame held more than 2^CNT_W-1 beats
// -----------------------------------------------------------------------------
module greater_stream #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             greater,
  output logic             equal,
  output logic             less,
  output logic             result,
  output logic             frame_valid,
  output logic [WIDTH-1:0] frame_max,
  output logic [CNT_W-1:0] frame_max_idx,
  output logic [CNT_W-1:0] frame_count,
  output logic             frame_ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Strict x > y under the configured signedness.
  function automatic logic is_greater(input logic [WIDTH-1:0] x,
                                      input logic [WIDTH-1:0] y);
    if (SIGNED) begin
      return ($signed(x) > $signed(y));
    end else begin
      return (x > y);
    end
  endfunction

  // Output pipeline registers
  logic             r_out_valid;
  logic             r_greater;
  logic             r_equal;
  logic             r_less;
  logic             r_result;

  // Frame tracker state
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_run_max;
  logic [CNT_W-1:0] r_run_idx;
  logic             r_first;
  logic             r_ovf;

  // Frame summary registers
  logic             r_frame_valid;
  logic [WIDTH-1:0] r_frame_max;
  logic [CNT_W-1:0] r_frame_max_idx;
  logic [CNT_W-1:0] r_frame_count;
  logic             r_frame_ovf;

  // Combinational helpers
  logic             w_accept;
  logic             w_gt;
  logic             w_eq;
  logic             w_lt;
  logic             w_result;
  logic             w_new_max;
  logic             w_cnt_sat;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [WIDTH-1:0] w_max_nxt;
  logic [CNT_W-1:0] w_idx_nxt;
  logic             w_ovf_nxt;

  // The single output slot frees up in the same cycle it is drained.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Operand relations; exactly one of gt/eq/lt is set for any operand pair.
  always_comb begin
    w_eq = (a == b);
    w_gt = is_greater(a, b);
    w_lt = !w_eq && !w_gt;
  end

  // Mode-selected relation of the incoming beat.
  always_comb begin
    w_result = 1'b0;
    case (mode)
      2'b00:   w_result = w_gt;
      2'b01:   w_result = w_gt | w_eq;
      2'b10:   w_result = w_lt;
      2'b11:   w_result = w_eq;
      default: w_result = 1'b0;
    endcase
  end

  // Next state of the frame tracker if the current beat is accepted.
  always_comb begin
    w_cnt_sat = (r_cnt == CNT_MAX);
    w_ovf_nxt = r_ovf | w_cnt_sat;
    w_cnt_inc = CNT_ZERO;
    if (w_cnt_sat) begin
      w_cnt_inc = r_cnt;
    end else begin
      w_cnt_inc = r_cnt + CNT_ONE;
    end
    // The first beat always seeds the max; afterwards only a strictly
    // greater value replaces it, so ties keep the earliest index.
    w_new_max = r_first || is_greater(a, r_run_max);
    w_max_nxt = r_run_max;
    w_idx_nxt = r_run_idx;
    if (r_first) begin
      w_max_nxt = a;
      w_idx_nxt = CNT_ZERO;
    end else if (w_new_max) begin
      w_max_nxt = a;
      w_idx_nxt = r_cnt;
    end else begin
      w_max_nxt = r_run_max;
      w_idx_nxt = r_run_idx;
    end
  end

  // Output slot: load on accept, clear on drain, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_greater   <= 1'b0;
      r_equal     <= 1'b0;
      r_less      <= 1'b0;
      r_result    <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_greater   <= w_gt;
      r_equal     <= w_eq;
      r_less      <= w_lt;
      r_result    <= w_result;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Running frame state: advance on every accepted beat, rearm at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= CNT_ZERO;
      r_run_max <= {WIDTH{1'b0}};
      r_run_idx <= CNT_ZERO;
      r_first   <= 1'b1;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_run_max <= w_max_nxt;
      r_run_idx <= w_idx_nxt;
      if (in_last) begin
        r_cnt   <= CNT_ZERO;
        r_first <= 1'b1;
        r_ovf   <= 1'b0;
      end else begin
        r_cnt   <= w_cnt_inc;
        r_first <= 1'b0;
        r_ovf   <= w_ovf_nxt;
      end
    end
  end

  // Frame summary: capture on the closing beat, pulse valid for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_valid   <= 1'b0;
      r_frame_max     <= {WIDTH{1'b0}};
      r_frame_max_idx <= CNT_ZERO;
      r_frame_count   <= CNT_ZERO;
      r_frame_ovf     <= 1'b0;
    end else if (w_accept && in_last) begin
      r_frame_valid   <= 1'b1;
      r_frame_max     <= w_max_nxt;
      r_frame_max_idx <= w_idx_nxt;
      r_frame_count   <= w_cnt_inc;
      r_frame_ovf     <= w_ovf_nxt;
    end else begin
      r_frame_valid   <= 1'b0;
    end
  end

  assign out_valid     = r_out_valid;
  assign greater       = r_greater;
  assign equal         = r_equal;
  assign less          = r_less;
  assign result        = r_result;
  assign frame_valid   = r_frame_valid;
  assign frame_max     = r_frame_max;
  assign frame_max_idx = r_frame_max_idx;
  assign frame_count   = r_frame_count;
  assign frame_ovf     = r_frame_ovf;

endmodule
